// File: rtl/trng_str_ctrl.sv
// Sequencer/sampler for a self-timed-ring TRNG: ring release, warm-up,
// synchronized XOR sampling into words, valid/ready delivery, repetition health test.
module trng_str_ctrl #(
  parameter int LEN     = 8,
  parameter int WIDTH   = 32,
  parameter int WARMUP  = 256,
  parameter int DIV     = 4,
  parameter int REP_MAX = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             str_rstn,
  input  logic [LEN-1:0]   str_sout,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             err
);

  localparam int WW = $clog2(WARMUP);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WARM, S_COLLECT, S_HOLD, S_FAIL} state_t;

  state_t           state, state_nxt;
  logic [LEN-1:0]   sync1, sync2;
  logic             raw, prev;
  logic [WW-1:0]    warm_cnt;
  logic [DW-1:0]    cnt_div;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sr;
  logic [RW-1:0]    rep_cnt, rep_nxt;
  logic             sample, word_done, rep_fail, run_nxt;

  assign raw = ^sync2;

  always_comb begin
    sample    = 1'b0;
    word_done = 1'b0;
    rep_fail  = 1'b0;
    rep_nxt   = rep_cnt;
    state_nxt = state;
    sample    = (state == S_COLLECT) && en && (cnt_div == DW'(DIV - 1));
    // rep_cnt==0 marks the first sample since IDLE
    rep_nxt   = (rep_cnt == '0 || raw != prev) ? RW'(1) : rep_cnt + RW'(1);
    rep_fail  = sample && (rep_nxt == RW'(REP_MAX));
    word_done = sample && (bit_cnt == BW'(WIDTH - 1));
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_WARM;
        S_WARM:    if (warm_cnt == WW'(WARMUP - 1)) state_nxt = S_COLLECT;
        S_COLLECT: begin
          if (rep_fail)       state_nxt = S_FAIL;
          else if (word_done) state_nxt = S_HOLD;
        end
        S_HOLD:    if (valid && ready) state_nxt = S_COLLECT;
        S_FAIL:    state_nxt = S_FAIL;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign run_nxt = (state_nxt == S_WARM) || (state_nxt == S_COLLECT) ||
                   (state_nxt == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= 1'b0;
      warm_cnt <= '0;
      cnt_div  <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rep_cnt  <= '0;
      data     <= '0;
      valid    <= 1'b0;
      str_rstn <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync1    <= str_sout;
      sync2    <= sync1;
      // outputs registered from next state so they line up with the state
      str_rstn <= run_nxt;
      busy     <= run_nxt;
      err      <= (state_nxt == S_FAIL);
      valid    <= (state_nxt == S_HOLD);

      warm_cnt <= (state == S_WARM) ? warm_cnt + WW'(1) : '0;

      if (state == S_COLLECT)
        cnt_div <= (cnt_div == DW'(DIV - 1)) ? '0 : cnt_div + DW'(1);
      else
        cnt_div <= '0;

      if (sample) begin
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
        sr      <= {sr[WIDTH-2:0], raw};
        prev    <= raw;
        rep_cnt <= rep_nxt;
      end else if (state != S_COLLECT) begin
        bit_cnt <= '0;
      end

      if (state == S_IDLE) rep_cnt <= '0;

      if (word_done && !rep_fail) data <= {sr[WIDTH-2:0], raw};
    end
  end

endmodule
